// File: rtl/bram_client_pkg.sv
// Shared constants and helpers for the byte-enable BRAM client.
// Latency and credit-width helpers keep the top and the FIFO in agreement.
package bram_client_pkg;

  typedef enum logic [1:0] {
    REQ_IDLE,
    REQ_READ,
    REQ_WRITE,
    REQ_NOP
  } req_kind_e;

  function automatic int read_latency(input int pipelined);
    return 1 + pipelined;
  endfunction

  function automatic int credit_width(input int rsp_depth);
    return $clog2(rsp_depth + 1);
  endfunction

endpackage

// File: rtl/bram_be_client_rsp_fifo.sv
// Response FIFO holding captured BRAM read data until the consumer takes it.
// The head entry is presented directly so it stays stable until dequeued.
module bram_be_client_rsp_fifo
  import bram_client_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 4,
  localparam int CW = credit_width(RSP_DEPTH),
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  enq,
  input  logic [DATA_WIDTH-1:0] enq_data,
  input  logic                  deq,
  output logic [DATA_WIDTH-1:0] data,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_enq;
  logic                  do_deq;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(RSP_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign do_enq = enq && (count != CW'(RSP_DEPTH));
  assign do_deq = deq && (count != '0);
  assign data   = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_enq) begin
      mem[wr_ptr] <= enq_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_deq) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bram_be_client.sv
// Byte-enable BRAM client: issues requests straight to the BRAM and returns
// read data in order through a credit-controlled response FIFO.
module bram_be_client
  import bram_client_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int WE_WIDTH   = 4,
  parameter int PIPELINED  = 0,
  parameter int RSP_DEPTH  = 4,
  localparam int L  = read_latency(PIPELINED),
  localparam int CW = credit_width(RSP_DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [WE_WIDTH-1:0]   req_byteen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  bram_en,
  output logic [WE_WIDTH-1:0]   bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_di,
  input  logic [DATA_WIDTH-1:0] bram_do
);

  req_kind_e     kind;
  logic [L-1:0]  tracker;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] inflight;
  logic [CW:0]   used;
  logic          has_credit;
  logic          accept;
  logic          rd_issue;

  always_comb begin
    kind = REQ_IDLE;
    if (req_valid) begin
      if (!req_write) begin
        kind = REQ_READ;
      end else if (req_byteen == '0) begin
        kind = REQ_NOP;
      end else begin
        kind = REQ_WRITE;
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < L; i++) begin
      inflight = inflight + CW'(tracker[i]);
    end
  end

  // Credits count both queued responses and reads still inside the BRAM,
  // so every issued read is guaranteed a FIFO slot when its data returns.
  assign used       = {1'b0, fifo_count} + {1'b0, inflight};
  assign has_credit = used < (CW + 1)'(RSP_DEPTH);

  assign req_ready = RST_N && (req_write || has_credit);
  assign accept    = req_valid && req_ready;
  assign rd_issue  = accept && (kind == REQ_READ);

  assign bram_en   = accept && ((kind == REQ_READ) || (kind == REQ_WRITE));
  assign bram_we   = (accept && (kind == REQ_WRITE)) ? req_byteen : '0;
  assign bram_addr = req_addr;
  assign bram_di   = req_wdata;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tracker <= '0;
    end else begin
      tracker[0] <= rd_issue;
      for (int i = 1; i < L; i++) begin
        tracker[i] <= tracker[i-1];
      end
    end
  end

  assign rsp_valid = (fifo_count != '0);

  bram_be_client_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .enq      (tracker[L-1]),
    .enq_data (bram_do),
    .deq      (rsp_valid && rsp_ready),
    .data     (rsp_data),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_bram_be_client.sv
// Scoreboard bench for bram_be_client, exercising both read latencies side by side
// against a BRAM model and a spec-level memory/response reference model.
module tb_bram_be_client;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int WW    = 4;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic log_check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int P = g;
    localparam int L = 1 + P;

    logic          rst_n;
    logic          req_valid, req_ready, req_write;
    logic [WW-1:0] req_byteen;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          bram_en;
    logic [WW-1:0] bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_di, bram_do;
    bit            fin = 1'b0;

    bram_be_client #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .WE_WIDTH   (WW),
      .PIPELINED  (P),
      .RSP_DEPTH  (DEPTH)
    ) dut (
      .CLK        (CLK),
      .RST_N      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_byteen (req_byteen),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .bram_en    (bram_en),
      .bram_we    (bram_we),
      .bram_addr  (bram_addr),
      .bram_di    (bram_di),
      .bram_do    (bram_do)
    );

    // BRAM with byte write enables and L cycles of read latency
    logic [DW-1:0] ram [1<<AW];
    logic [DW-1:0] q1, q2;

    initial begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
    end

    always @(posedge CLK) begin
      if (bram_en) begin
        q1 <= ram[bram_addr];
        for (int b = 0; b < WW; b++) begin
          if (bram_we[b]) ram[bram_addr][b*8 +: 8] <= bram_di[b*8 +: 8];
        end
      end
      q2 <= q1;
    end

    assign bram_do = (P == 1) ? q2 : q1;

    logic [DW-1:0] ref_mem [1<<AW];
    logic [DW-1:0] sb [$];
    int            cyc = 0;
    int            first_acc;
    int            first_valid;
    bit            arm;

    always @(posedge CLK) cyc++;

    task automatic check_output(input string n, input logic [63:0] a, input logic [63:0] e);
      log_check($sformatf("p%0d_%s", P, n), a, e);
    endtask

    // Monitor: pops the scoreboard on every handshake, checks hold under stall
    initial begin : monitor
      bit            stall_prev;
      logic [DW-1:0] stall_data;
      logic [DW-1:0] exp;
      stall_prev = 1'b0;
      stall_data = '0;
      forever begin
        @(negedge CLK);
        if (!rst_n) begin
          stall_prev = 1'b0;
        end else begin
          if (stall_prev && rsp_valid) check_output("rsp_hold", rsp_data, stall_data);
          if (arm && rsp_valid) begin
            first_valid = cyc;
            arm = 1'b0;
          end
          if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL p%0d_unexpected_rsp actual=0x%0h required=none", P, rsp_data);
            end else begin
              exp = sb.pop_front();
              check_output("rsp_data", rsp_data, exp);
            end
          end
          stall_prev = rsp_valid && !rsp_ready;
          stall_data = rsp_data;
        end
      end
    end

    // One request cycle: starts and ends just after a rising edge
    task automatic apply_stimulus(input bit wr, input logic [WW-1:0] be, input logic [AW-1:0] a,
                                  input logic [DW-1:0] d, output bit acc);
      bit en_exp;
      req_valid  = 1'b1;
      req_write  = wr;
      req_byteen = be;
      req_addr   = a;
      req_wdata  = d;
      @(negedge CLK);
      acc    = req_ready;
      en_exp = acc && (!wr || (be != '0));
      check_output("bram_en", bram_en, en_exp);
      check_output("bram_we", bram_we, (acc && wr) ? be : '0);
      if (en_exp) check_output("bram_addr", bram_addr, a);
      if (en_exp && wr) check_output("bram_di", bram_di, d);
      if (wr) check_output("write_ready", req_ready, 1);
      if (acc) begin
        if (wr) begin
          for (int b = 0; b < WW; b++) begin
            if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
          end
        end else begin
          sb.push_back(ref_mem[a]);
          if (first_acc < 0) first_acc = cyc;
        end
      end
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
      repeat (n) begin
        @(posedge CLK);
        #1;
      end
    endtask

    task automatic drain();
      for (int k = 0; k < 60; k++) begin
        if (sb.size() == 0) break;
        idle(1);
      end
      check_output("drain", sb.size(), 0);
    endtask

    initial begin : driver
      bit acc;
      int issued, nacc, ncyc, seen;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_byteen = '0;
      req_addr   = '0;
      req_wdata  = '0;
      rsp_ready  = 1'b1;
      first_acc  = -1;
      first_valid = -1;
      arm        = 1'b0;
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;

      repeat (2) @(posedge CLK);
      #1;
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_byteen = 4'hF;
      @(negedge CLK);
      check_output("rst_req_ready", req_ready, 0);
      check_output("rst_rsp_valid", rsp_valid, 0);
      check_output("rst_bram_en", bram_en, 0);
      check_output("rst_bram_we", bram_we, 0);
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
      req_write = 1'b0;
      rst_n     = 1'b1;
      @(negedge CLK);
      check_output("ready_after_reset", req_ready, 1);
      @(posedge CLK);
      #1;

      // Read-after-write to the same word and accept-to-valid latency
      first_acc = -1;
      first_valid = -1;
      arm = 1'b1;
      apply_stimulus(1'b1, 4'hF, 10'd5, 32'hDEADBEEF, acc);
      apply_stimulus(1'b0, 4'h0, 10'd5, 32'h0, acc);
      idle(6);
      check_output("raw_latency", first_valid - first_acc, L + 1);
      drain();

      // Partial byte-enable merge, then a byte-enable-zero write must be a no-op
      apply_stimulus(1'b1, 4'hF, 10'd9, 32'h11223344, acc);
      apply_stimulus(1'b1, 4'b0101, 10'd9, 32'hAABBCCDD, acc);
      apply_stimulus(1'b0, 4'h0, 10'd9, 32'h0, acc);
      apply_stimulus(1'b1, 4'h0, 10'd9, 32'hFFFFFFFF, acc);
      apply_stimulus(1'b0, 4'h0, 10'd9, 32'h0, acc);
      drain();

      // Backpressure: only DEPTH reads fit until the consumer drains
      rsp_ready = 1'b0;
      issued = 0;
      for (int c = 0; c < 12; c++) begin
        if (issued < 6) begin
          apply_stimulus(1'b0, 4'h0, AW'(100 + issued), 32'h0, acc);
          if (acc) issued++;
        end else begin
          idle(1);
        end
      end
      check_output("bp_accepts", issued, 4);
      apply_stimulus(1'b0, 4'h0, AW'(100 + issued), 32'h0, acc);
      if (acc) issued++;
      check_output("bp_read_blocked", acc, 0);
      apply_stimulus(1'b1, 4'hF, 10'd200, $urandom, acc);
      check_output("bp_write_accepted", acc, 1);
      rsp_ready = 1'b1;
      for (int c = 0; c < 20 && issued < 6; c++) begin
        apply_stimulus(1'b0, 4'h0, AW'(100 + issued), 32'h0, acc);
        if (acc) issued++;
      end
      check_output("bp_remaining", issued, 6);
      drain();

      // Back-to-back reads at full rate
      first_acc = -1;
      first_valid = -1;
      arm = 1'b1;
      nacc = 0;
      ncyc = 0;
      while (nacc < 16 && ncyc < 40) begin
        apply_stimulus(1'b0, 4'h0, AW'($urandom_range(0, 255)), 32'h0, acc);
        ncyc++;
        if (acc) nacc++;
      end
      check_output("b2b_accepts", nacc, 16);
      check_output("b2b_cycles", ncyc, 16);
      check_output("b2b_latency", first_valid - first_acc, L + 1);
      drain();

      // Random mix of reads, writes and consumer stalls
      for (int c = 0; c < 300; c++) begin
        rsp_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) begin
          idle(1);
        end else begin
          apply_stimulus(1'($urandom_range(0, 1)), WW'($urandom_range(0, 15)),
                         AW'($urandom_range(0, 15)), $urandom, acc);
        end
      end
      rsp_ready = 1'b1;
      drain();

      // Reset with reads in flight and one response queued
      rsp_ready = 1'b0;
      for (int i = 0; i < L + 1; i++) begin
        apply_stimulus(1'b0, 4'h0, AW'(i), 32'h0, acc);
      end
      check_output("mr_queued", rsp_valid, 1);
      rst_n = 1'b0;
      #1;
      check_output("mr_rsp_valid", rsp_valid, 0);
      check_output("mr_req_ready", req_ready, 0);
      sb.delete();
      repeat (2) @(posedge CLK);
      #1;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge CLK);
        if (rsp_valid) seen++;
        @(posedge CLK);
        #1;
      end
      check_output("mr_no_stale", seen, 0);
      apply_stimulus(1'b0, 4'h0, 10'd5, 32'h0, acc);
      check_output("mr_read_accepted", acc, 1);
      drain();

      fin = 1'b1;
    end
  end

  initial begin
    fork
      wait (inst[0].fin && inst[1].fin);
      #400000;
    join_any
    disable fork;
    if (!(inst[0].fin && inst[1].fin)) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout actual=unfinished required=finished");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
